// File: rtl/sr_imem_loader.sv
// rtl/sr_imem_loader.sv - schoolRISCV instruction memory with byte-stream program loader (option: SR_IMEM_LOADER_BOUND_EN)
module sr_imem_loader #(
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           imAddr,
    output logic [31:0]           imData,
    output logic                  cpuRstN,
    input  logic                  ldStart,
    input  logic                  ldValid,
    input  logic [7:0]            ldData,
    output logic                  ldReady,
    output logic                  busy,
    output logic                  ldOvf,
    output logic [ADDR_WIDTH:0]   wordCount
);

    localparam int          DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           len_q, len_d;
    logic [23:0]           buf_q, buf_d;
    logic                  ovf_q, ovf_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic                  cpu_rstn_q;

    logic [31:0]           mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    logic                  accept;
    logic                  word_in_range;
    logic                  addr_in_range;

    assign ldReady   = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign ldOvf     = ovf_q;
    assign wordCount = wcnt_q;
    assign cpuRstN   = cpu_rstn_q;

    assign accept        = ldValid & ldReady;
    assign word_in_range = ({1'b0, word_idx_q} < DEPTH_W);
    assign mem_waddr     = word_idx_q[ADDR_WIDTH-1:0];
    assign mem_wdata     = {ldData, buf_q};

    // Loader sequencing: header parse, byte assembly into words, restart handling
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        buf_d      = buf_q;
        ovf_d      = ovf_q;
        wcnt_d     = wcnt_q;
        mem_we     = 1'b0;

        if (ldStart) begin
            // Restart discards any byte offered this cycle
            state_d    = S_LEN0;
            byte_idx_d = 2'd0;
            word_idx_d = 16'd0;
            if (state_q == S_IDLE) begin
                ovf_d  = 1'b0;
                wcnt_d = '0;
            end
        end else if (accept) begin
            case (state_q)
                S_LEN0: begin
                    len_lo_d = ldData;
                    state_d  = S_LEN1;
                end
                S_LEN1: begin
                    len_d      = {ldData, len_lo_q};
                    byte_idx_d = 2'd0;
                    word_idx_d = 16'd0;
                    if ({1'b0, len_d} > DEPTH_W) begin
                        ovf_d = 1'b1;
                    end
                    state_d = (len_d == 16'd0) ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (byte_idx_q == 2'd3) begin
                        byte_idx_d = 2'd0;
                        // Words past the array are consumed but dropped, so the count saturates at DEPTH
                        if (word_in_range) begin
                            mem_we = 1'b1;
                            wcnt_d = wcnt_q + (ADDR_WIDTH+1)'(1);
                        end
                        if (word_idx_q == len_q - 16'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            word_idx_d = word_idx_q + 16'd1;
                        end
                    end else begin
                        buf_d[{byte_idx_q, 3'b000} +: 8] = ldData;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers; core reset follows the next state so it releases with the last write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 2'd0;
            word_idx_q <= 16'd0;
            len_lo_q   <= 8'd0;
            len_q      <= 16'd0;
            buf_q      <= 24'd0;
            ovf_q      <= 1'b0;
            wcnt_q     <= '0;
            cpu_rstn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            buf_q      <= buf_d;
            ovf_q      <= ovf_d;
            wcnt_q     <= wcnt_d;
            cpu_rstn_q <= (state_d == S_IDLE);
        end
    end

    // Program storage; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign addr_in_range = (imAddr[31:ADDR_WIDTH] == '0);

    // Combinational fetch, blocked while a load is rewriting the program
    always_comb begin
        imData = NOP_WORD;
        if (!busy && addr_in_range) begin
`ifdef SR_IMEM_LOADER_BOUND_EN
            if ({1'b0, imAddr[ADDR_WIDTH-1:0]} < wcnt_q) begin
                imData = mem[imAddr[ADDR_WIDTH-1:0]];
            end
`else
            imData = mem[imAddr[ADDR_WIDTH-1:0]];
`endif
        end
    end

endmodule
